// File: rtl/plot_receiver.sv
// Sink for the (x, y, colour) plot stream: framebuffer write pipeline plus a sweep-order checker.
// Writes appear two cycles after acceptance; ready is low only in DONE/ERROR, until ack.
module plot_receiver #(
   parameter int WIDTH       = 160,
   parameter int HEIGHT      = 120,
   parameter int COLOUR_BITS = 3
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   plot,
   input  logic [7:0]             x_in,
   input  logic [6:0]             y_in,
   input  logic [COLOUR_BITS-1:0] colour_in,
   output logic                   ready,
   input  logic                   ack,
   output logic [14:0]            fb_addr,
   output logic [COLOUR_BITS-1:0] fb_data,
   output logic                   fb_we,
   output logic [14:0]            pixel_count,
   output logic                   frame_done,
   output logic                   order_error,
   output logic                   oob_drop
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_ERROR} state_t;

   localparam logic [14:0] W15        = 15'(WIDTH);
   localparam logic [14:0] LAST_COUNT = 15'(WIDTH * HEIGHT - 1);
   localparam logic [7:0]  X_LAST     = 8'(WIDTH - 1);

   // sweep checker state
   state_t      state_q, state_d;
   logic [7:0]  exp_x_q, exp_x_d;
   logic [6:0]  exp_y_q, exp_y_d;
   logic [14:0] count_q, count_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   // input capture register (edge of acceptance)
   logic                   cap_vld_q, cap_vld_d;
   logic                   cap_inr_q, cap_inr_d;
   logic [7:0]             cap_x_q, cap_x_d;
   logic [6:0]             cap_y_q, cap_y_d;
   logic [COLOUR_BITS-1:0] cap_col_q, cap_col_d;

   // stage 1
   logic                   s1_vld_q, s1_vld_d;
   logic                   s1_inr_q, s1_inr_d;
   logic [7:0]             s1_x_q, s1_x_d;
   logic [6:0]             s1_y_q, s1_y_d;
   logic [COLOUR_BITS-1:0] s1_col_q, s1_col_d;

   // stage 2 (framebuffer port)
   logic                   fb_we_q, fb_we_d;
   logic [14:0]            fb_addr_q, fb_addr_d;
   logic [COLOUR_BITS-1:0] fb_data_q, fb_data_d;

   logic accept;
   logic in_range;
   logic hit;

   assign accept   = plot && ready_q;
   assign in_range = (int'(x_in) < WIDTH) && (int'(y_in) < HEIGHT);
   assign hit      = (x_in == exp_x_q) && (y_in == exp_y_q);

   // exp stays at (0,0) throughout IDLE, so a hit in IDLE means the sweep origin
   always_comb begin
      state_d = state_q;
      exp_x_d = exp_x_q;
      exp_y_d = exp_y_q;
      count_d = count_q;
      ready_d = ready_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_RECV: begin
            if (accept && in_range) begin
               if (hit) begin
                  count_d = count_q + 15'd1;
                  if (exp_x_q == X_LAST) begin
                     exp_x_d = '0;
                     exp_y_d = exp_y_q + 7'd1;
                  end else begin
                     exp_x_d = exp_x_q + 8'd1;
                  end
                  if (count_q == LAST_COUNT) begin
                     state_d = S_DONE;
                     ready_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_RECV;
                  end
               end else if (state_q == S_RECV) begin
                  state_d = S_ERROR;
                  ready_d = 1'b0;
                  err_d   = 1'b1;
               end
            end
         end
         default: begin
            if (ack) begin
               state_d = S_IDLE;
               exp_x_d = '0;
               exp_y_d = '0;
               count_d = '0;
               ready_d = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      cap_vld_d = accept;
      cap_inr_d = cap_inr_q;
      cap_x_d   = cap_x_q;
      cap_y_d   = cap_y_q;
      cap_col_d = cap_col_q;
      if (accept) begin
         cap_inr_d = in_range;
         cap_x_d   = x_in;
         cap_y_d   = y_in;
         cap_col_d = colour_in;
      end

      s1_vld_d = cap_vld_q;
      s1_inr_d = cap_inr_q;
      s1_x_d   = cap_x_q;
      s1_y_d   = cap_y_q;
      s1_col_d = cap_col_q;

      fb_we_d   = s1_vld_q && s1_inr_q;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      if (s1_vld_q && s1_inr_q) begin
         fb_addr_d = 15'(s1_y_q) * W15 + 15'(s1_x_q);
         fb_data_d = s1_col_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         exp_x_q   <= '0;
         exp_y_q   <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cap_vld_q <= 1'b0;
         cap_inr_q <= 1'b0;
         cap_x_q   <= '0;
         cap_y_q   <= '0;
         cap_col_q <= '0;
         s1_vld_q  <= 1'b0;
         s1_inr_q  <= 1'b0;
         s1_x_q    <= '0;
         s1_y_q    <= '0;
         s1_col_q  <= '0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_x_q   <= exp_x_d;
         exp_y_q   <= exp_y_d;
         count_q   <= count_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cap_vld_q <= cap_vld_d;
         cap_inr_q <= cap_inr_d;
         cap_x_q   <= cap_x_d;
         cap_y_q   <= cap_y_d;
         cap_col_q <= cap_col_d;
         s1_vld_q  <= s1_vld_d;
         s1_inr_q  <= s1_inr_d;
         s1_x_q    <= s1_x_d;
         s1_y_q    <= s1_y_d;
         s1_col_q  <= s1_col_d;
         fb_we_q   <= fb_we_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
      end
   end

   assign ready       = ready_q;
   assign pixel_count = count_q;
   assign frame_done  = done_q;
   assign order_error = err_q;
   assign fb_we       = fb_we_q;
   assign fb_addr     = fb_addr_q;
   assign fb_data     = fb_data_q;
   assign oob_drop    = s1_vld_q && !s1_inr_q;

endmodule

// File: tb/tb_plot_receiver.sv
// Scoreboarded bench for plot_receiver: directed sweeps, out-of-range drops, ack handling, mid-sweep reset.
module tb_plot_receiver;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        plot = 1'b0;
   logic        ack = 1'b0;
   logic [7:0]  x_in = '0;
   logic [6:0]  y_in = '0;
   logic [2:0]  colour_in = '0;
   logic        ready, fb_we, frame_done, order_error, oob_drop;
   logic [14:0] fb_addr, pixel_count;
   logic [2:0]  fb_data;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int oob_seen = 0;

   typedef struct {
      logic [14:0] addr;
      logic [2:0]  data;
      int          at;
   } wr_t;

   wr_t exp_q[$];

   plot_receiver #(.WIDTH(160), .HEIGHT(120), .COLOUR_BITS(3)) dut (
      .clk(clk), .resetn(resetn), .plot(plot), .x_in(x_in), .y_in(y_in),
      .colour_in(colour_in), .ready(ready), .ack(ack), .fb_addr(fb_addr),
      .fb_data(fb_data), .fb_we(fb_we), .pixel_count(pixel_count),
      .frame_done(frame_done), .order_error(order_error), .oob_drop(oob_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every framebuffer write must match the oldest expected write, in cycle
   always @(negedge clk) begin : mon
      wr_t e;
      if (oob_drop) oob_seen++;
      if (fb_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr=%0d data=%0d, want no write", fb_addr, fb_data);
         end else begin
            e = exp_q.pop_front();
            if (fb_addr !== e.addr || fb_data !== e.data || cyc != e.at) begin
               fails++;
               $display("FAIL write: got addr=%0d data=%0d cyc=%0d, want addr=%0d data=%0d cyc=%0d",
                        fb_addr, fb_data, cyc, e.addr, e.data, e.at);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, expv);
      end
   endtask

   // drive one cycle from a negedge; wr means this pixel is expected to be written
   task automatic step(input logic p, input int x, input int y, input logic a, input logic wr);
      wr_t w;
      plot      = p;
      x_in      = 8'(x);
      y_in      = 7'(y);
      colour_in = 3'((x + y) % 8);
      ack       = a;
      if (wr) begin
         w.addr = 15'(y * 160 + x);
         w.data = 3'((x + y) % 8);
         w.at   = cyc + 3;
         exp_q.push_back(w);
      end
      @(negedge clk);
      plot = 1'b0;
      ack  = 1'b0;
   endtask

   task automatic sweep(input int n, input int bad);
      for (int i = 0; i < n; i++) begin
         int x;
         int y;
         x = i % 160;
         y = i / 160;
         if (i == bad) x = x + 1;
         step(1'b1, x, y, 1'b0, 1'b1);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, int'(ready), 1);
      chk({tag, "_fb_we"}, int'(fb_we), 0);
      chk({tag, "_fb_addr"}, int'(fb_addr), 0);
      chk({tag, "_fb_data"}, int'(fb_data), 0);
      chk({tag, "_count"}, int'(pixel_count), 0);
      chk({tag, "_done"}, int'(frame_done), 0);
      chk({tag, "_err"}, int'(order_error), 0);
      chk({tag, "_oob"}, int'(oob_drop), 0);
   endtask

   task automatic do_ack(input string tag);
      step(1'b0, 0, 0, 1'b1, 1'b0);
      chk({tag, "_ack_count"}, int'(pixel_count), 0);
      chk({tag, "_ack_ready"}, int'(ready), 1);
      chk({tag, "_ack_flags"}, int'({frame_done, order_error}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk_reset_vals("rst");
      resetn = 1'b1;
      @(negedge clk);

      // out-of-range pixels in IDLE
      step(1'b1, 160, 0, 1'b0, 1'b0);
      chk("oob_not_yet", int'(oob_drop), 0);
      step(1'b0, 0, 0, 1'b0, 1'b0);
      chk("oob_pulse", int'(oob_drop), 1);
      step(1'b0, 0, 0, 1'b0, 1'b0);
      chk("oob_one_cycle", int'(oob_drop), 0);
      step(1'b1, 0, 120, 1'b0, 1'b0);
      step(1'b1, 255, 127, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b0, 1'b0);
      chk("oob_pulses", oob_seen, 3);
      chk("oob_count", int'(pixel_count), 0);
      chk("oob_ready", int'(ready), 1);

      // stray pixel in IDLE, then sweep start
      step(1'b1, 3, 3, 1'b0, 1'b1);
      chk("stray_count", int'(pixel_count), 0);
      step(1'b1, 0, 0, 1'b0, 1'b1);
      chk("start_count", int'(pixel_count), 1);
      step(1'b1, 1, 0, 1'b0, 1'b1);
      chk("second_count", int'(pixel_count), 2);
      chk("recv_ready", int'(ready), 1);

      // plot every other cycle with ack pulses in RECV
      for (int i = 2; i < 10; i++) begin
         step(1'b1, i, 0, 1'(i % 2 == 0), 1'b1);
         chk("toggle_hi_count", int'(pixel_count), i + 1);
         step(1'b0, 0, 0, 1'b1, 1'b0);
         chk("toggle_lo_count", int'(pixel_count), i + 1);
      end
      chk("toggle_ready", int'(ready), 1);

      // out-of-order pixel, then ignored pixel, then ack with simultaneous plot
      step(1'b1, 0, 0, 1'b0, 1'b1);
      chk("misorder_err", int'(order_error), 1);
      chk("misorder_ready", int'(ready), 0);
      chk("misorder_count", int'(pixel_count), 10);
      step(1'b1, 5, 5, 1'b0, 1'b0);
      chk("err_hold_count", int'(pixel_count), 10);
      chk("err_hold_flag", int'(order_error), 1);
      step(1'b1, 6, 6, 1'b1, 1'b0);
      chk("ack_wins_err", int'(order_error), 0);
      chk("ack_wins_count", int'(pixel_count), 0);
      chk("ack_wins_ready", int'(ready), 1);
      drain();

      // full raster
      sweep(19200, -1);
      chk("full_done", int'(frame_done), 1);
      chk("full_count", int'(pixel_count), 19200);
      chk("full_ready", int'(ready), 0);
      chk("full_err", int'(order_error), 0);
      drain();
      chk("full_done_hold", int'(frame_done), 1);
      do_ack("full");

      // sweep with (5,2) replaced by (6,2)
      sweep(326, 325);
      chk("bad_err", int'(order_error), 1);
      chk("bad_count", int'(pixel_count), 325);
      chk("bad_ready", int'(ready), 0);
      chk("bad_done", int'(frame_done), 0);
      drain();
      do_ack("bad");

      // reset mid-sweep with writes in flight
      sweep(1000, -1);
      chk("pre_reset_count", int'(pixel_count), 1000);
      #2;
      resetn = 1'b0;
      #1;
      chk_reset_vals("async");
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      sweep(19200, -1);
      chk("resweep_done", int'(frame_done), 1);
      chk("resweep_count", int'(pixel_count), 19200);
      drain();
      do_ack("resweep");

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
